// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register: ID/EX stage register with load-use stall, flush and bubble counter
module id_ex_pipeline_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      idValid,
  input  logic                      idPcUpdate,
  input  logic                      idMemoryReadEnable,
  input  logic                      idMemoryWriteEnable,
  input  logic                      idRegisterWriteEnable,
  input  logic                      idPcAdderSrc,
  input  logic                      idWriteBackFromAluOrMemory,
  input  logic [1:0]                idAluSrc1,
  input  logic [1:0]                idAluSrc2,
  input  logic [2:0]                idAluOperation,
  input  logic [DATA_WIDTH-1:0]     idPc,
  input  logic [DATA_WIDTH-1:0]     idRs1Data,
  input  logic [DATA_WIDTH-1:0]     idRs2Data,
  input  logic [DATA_WIDTH-1:0]     idImmediate,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2,
  input  logic [REG_ADDR_WIDTH-1:0] idRd,
  input  logic                      idUsesRs1,
  input  logic                      idUsesRs2,
  input  logic [2:0]                idFunct3,
  input  logic                      idFunct7b5,
  input  logic                      flush,
  input  logic                      hold,
  output logic                      exValid,
  output logic                      exPcUpdate,
  output logic                      exMemoryReadEnable,
  output logic                      exMemoryWriteEnable,
  output logic                      exRegisterWriteEnable,
  output logic                      exPcAdderSrc,
  output logic                      exWriteBackFromAluOrMemory,
  output logic [1:0]                exAluSrc1,
  output logic [1:0]                exAluSrc2,
  output logic [2:0]                exAluOperation,
  output logic [DATA_WIDTH-1:0]     exPc,
  output logic [DATA_WIDTH-1:0]     exRs1Data,
  output logic [DATA_WIDTH-1:0]     exRs2Data,
  output logic [DATA_WIDTH-1:0]     exImmediate,
  output logic [REG_ADDR_WIDTH-1:0] exRs1,
  output logic [REG_ADDR_WIDTH-1:0] exRs2,
  output logic [REG_ADDR_WIDTH-1:0] exRd,
  output logic [2:0]                exFunct3,
  output logic                      exFunct7b5,
  output logic                      stallOut,
  output logic [CNT_WIDTH-1:0]      bubbleCount
);
  localparam int W = 18 + 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;
  logic [W-1:0] d, q;
  logic         hazard, kill;
  assign hazard = exValid & exMemoryReadEnable & (exRd != '0) & idValid &
                  ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));
  assign stallOut = ~flush & (hold | hazard);
  assign kill = flush | (~hold & hazard);
  // enables are gated by idValid so X from an invalid decode never reaches EX
  assign d = {idValid,
              idPcUpdate & idValid, idMemoryReadEnable & idValid,
              idMemoryWriteEnable & idValid, idRegisterWriteEnable & idValid,
              idPcAdderSrc, idWriteBackFromAluOrMemory, idAluSrc1, idAluSrc2,
              idAluOperation, idPc, idRs1Data, idRs2Data, idImmediate,
              idRs1, idRs2, idRd, idFunct3, idFunct7b5};
  assign {exValid, exPcUpdate, exMemoryReadEnable, exMemoryWriteEnable,
          exRegisterWriteEnable, exPcAdderSrc, exWriteBackFromAluOrMemory,
          exAluSrc1, exAluSrc2, exAluOperation, exPc, exRs1Data, exRs2Data,
          exImmediate, exRs1, exRs2, exRd, exFunct3, exFunct7b5} = q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) q <= '0;
    else if (kill) q <= '0;
    else if (!hold) q <= d;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) bubbleCount <= '0;
    else if (!flush && !hold && hazard && !(&bubbleCount)) bubbleCount <= bubbleCount + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb_id_ex_pipeline_register: directed checks of pass-through, load-use, flush, hold, reset and saturation
module tb_id_ex_pipeline_register;
  logic clk = 0, rstN = 0;
  logic idValid, idPcUpdate, idMemoryReadEnable, idMemoryWriteEnable, idRegisterWriteEnable;
  logic idPcAdderSrc, idWriteBackFromAluOrMemory, idUsesRs1, idUsesRs2, idFunct7b5, flush, hold;
  logic [1:0] idAluSrc1, idAluSrc2;
  logic [2:0] idAluOperation, idFunct3;
  logic [31:0] idPc, idRs1Data, idRs2Data, idImmediate;
  logic [4:0] idRs1, idRs2, idRd;
  logic exValid, exPcUpdate, exMemoryReadEnable, exMemoryWriteEnable, exRegisterWriteEnable;
  logic exPcAdderSrc, exWriteBackFromAluOrMemory, exFunct7b5, stallOut;
  logic [1:0] exAluSrc1, exAluSrc2, bubbleCount;
  logic [2:0] exAluOperation, exFunct3;
  logic [31:0] exPc, exRs1Data, exRs2Data, exImmediate;
  logic [4:0] exRs1, exRs2, exRd;
  int checks = 0, errors = 0;
  int exp_cnt [5] = '{1, 2, 3, 3, 3};

  id_ex_pipeline_register #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
    .clk(clk), .rstN(rstN), .idValid(idValid), .idPcUpdate(idPcUpdate),
    .idMemoryReadEnable(idMemoryReadEnable), .idMemoryWriteEnable(idMemoryWriteEnable),
    .idRegisterWriteEnable(idRegisterWriteEnable), .idPcAdderSrc(idPcAdderSrc),
    .idWriteBackFromAluOrMemory(idWriteBackFromAluOrMemory), .idAluSrc1(idAluSrc1),
    .idAluSrc2(idAluSrc2), .idAluOperation(idAluOperation), .idPc(idPc),
    .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImmediate(idImmediate),
    .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idFunct3(idFunct3), .idFunct7b5(idFunct7b5), .flush(flush), .hold(hold),
    .exValid(exValid), .exPcUpdate(exPcUpdate), .exMemoryReadEnable(exMemoryReadEnable),
    .exMemoryWriteEnable(exMemoryWriteEnable), .exRegisterWriteEnable(exRegisterWriteEnable),
    .exPcAdderSrc(exPcAdderSrc), .exWriteBackFromAluOrMemory(exWriteBackFromAluOrMemory),
    .exAluSrc1(exAluSrc1), .exAluSrc2(exAluSrc2), .exAluOperation(exAluOperation),
    .exPc(exPc), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data), .exImmediate(exImmediate),
    .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd), .exFunct3(exFunct3), .exFunct7b5(exFunct7b5),
    .stallOut(stallOut), .bubbleCount(bubbleCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {idValid, idPcUpdate, idMemoryReadEnable, idMemoryWriteEnable, idRegisterWriteEnable} = '0;
    {idPcAdderSrc, idWriteBackFromAluOrMemory, idUsesRs1, idUsesRs2, idFunct7b5} = '0;
    {idAluSrc1, idAluSrc2, idAluOperation, idFunct3} = '0;
    {idPc, idRs1Data, idRs2Data, idImmediate} = '0;
    {idRs1, idRs2, idRd} = '0;
  endtask

  task automatic set_lw(input logic [4:0] rd);
    idle;
    idValid = 1; idMemoryReadEnable = 1; idRegisterWriteEnable = 1; idWriteBackFromAluOrMemory = 1;
    idRs1 = 5'd1; idUsesRs1 = 1; idRd = rd; idFunct3 = 3'b010; idImmediate = 32'h10;
  endtask

  task automatic set_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    idle;
    idValid = 1; idRegisterWriteEnable = 1; idAluOperation = 3'b010;
    idRs1 = rs1; idRs2 = rs2; idRd = rd; idUsesRs1 = 1; idUsesRs2 = 1;
    idRs1Data = 32'd5; idRs2Data = 32'd7; idPc = 32'h100;
  endtask

  initial begin
    idle; flush = 0; hold = 0;
    #12;
    chk("reset_valid", exValid, 0);
    chk("reset_count", bubbleCount, 0);
    chk("reset_stall", stallOut, 0);
    @(negedge clk) rstN = 1;
    // pass-through ADD
    set_add(5'd1, 5'd2, 5'd3);
    tick;
    chk("pt_valid", exValid, 1);
    chk("pt_aluop", exAluOperation, 3'b010);
    chk("pt_rs1data", exRs1Data, 5);
    chk("pt_rs2data", exRs2Data, 7);
    chk("pt_rd", exRd, 3);
    chk("pt_regwr", exRegisterWriteEnable, 1);
    chk("pt_pc", exPc, 32'h100);
    // load-use bubble
    set_lw(5'd4);
    tick;
    chk("lu_ex_load", exMemoryReadEnable, 1);
    set_add(5'd5, 5'd4, 5'd6);
    idUsesRs1 = 0;
    #1 chk("lu_stall", stallOut, 1);
    tick;
    chk("lu_bubble_valid", exValid, 0);
    chk("lu_bubble_regwr", exRegisterWriteEnable, 0);
    chk("lu_count1", bubbleCount, 1);
    chk("lu_no_double_stall", stallOut, 0);
    tick;
    chk("lu_add_valid", exValid, 1);
    chk("lu_add_rd", exRd, 6);
    chk("lu_count_hold", bubbleCount, 1);
    // flush beats hazard
    set_lw(5'd4);
    tick;
    set_add(5'd4, 5'd8, 5'd7);
    flush = 1;
    #1 chk("fl_stall", stallOut, 0);
    tick;
    chk("fl_valid", exValid, 0);
    chk("fl_memrd", exMemoryReadEnable, 0);
    chk("fl_regwr", exRegisterWriteEnable, 0);
    chk("fl_count", bubbleCount, 1);
    flush = 0;
    tick;
    chk("fl_next_valid", exValid, 1);
    hold = 1; flush = 1;
    #1 chk("flh_stall", stallOut, 0);
    tick;
    chk("flh_valid", exValid, 0);
    chk("flh_regwr", exRegisterWriteEnable, 0);
    hold = 0; flush = 0;
    // hold freezes EX
    set_add(5'd1, 5'd2, 5'd9);
    tick;
    chk("hd_rd0", exRd, 9);
    hold = 1;
    set_add(5'd1, 5'd2, 5'd12);
    idRs1Data = 32'd99;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hd_stall", stallOut, 1);
      tick;
      chk("hd_rd", exRd, 9);
      chk("hd_rs1data", exRs1Data, 5);
      chk("hd_valid", exValid, 1);
    end
    hold = 0;
    // x0 never hazards
    set_lw(5'd0);
    tick;
    set_add(5'd0, 5'd0, 5'd2);
    #1 chk("x0_stall", stallOut, 0);
    tick;
    chk("x0_valid", exValid, 1);
    chk("x0_count", bubbleCount, 1);
    // asynchronous reset mid-run with a hazard pending
    set_lw(5'd4);
    tick;
    set_add(5'd4, 5'd4, 5'd5);
    #1 chk("rs_pre_stall", stallOut, 1);
    rstN = 0;
    #1;
    chk("rs_valid", exValid, 0);
    chk("rs_memrd", exMemoryReadEnable, 0);
    chk("rs_rd", exRd, 0);
    chk("rs_imm", exImmediate, 0);
    chk("rs_count", bubbleCount, 0);
    chk("rs_stall", stallOut, 0);
    hold = 1;
    #1 chk("rs_hold_stall", stallOut, 1);
    hold = 0;
    @(negedge clk) rstN = 1;
    // saturation at 2-bit width
    for (int i = 0; i < 5; i++) begin
      set_lw(5'd4);
      tick;
      set_add(5'd3, 5'd4, 5'd6);
      idUsesRs1 = 0;
      tick;
      chk("sat_count", bubbleCount, exp_cnt[i]);
      chk("sat_bubble", exValid, 0);
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
Decode-to-execute pipeline register for the 5-stage RISC-V core. It sits directly downstream of the decode-stage control unit. It latches that unit's control bundle together with operands, immediate and register indices, and presents them to EX one cycle later. It also contains the load-use hazard detector: it inserts bubbles, stalls fetch/decode, kills the slot on branch/jump flush, and keeps a saturating bubble counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of operands, immediate and PC
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 16, width of the load-use bubble counter

Ports:
clk  input  1  core clock, rising edge
rstN  input  1  asynchronous active-low reset
idValid  input  1  decode slot holds a real instruction
idPcUpdate, idMemoryReadEnable, idMemoryWriteEnable, idRegisterWriteEnable, idPcAdderSrc, idWriteBackFromAluOrMemory  input  1 each  control bundle from the decode control unit
idAluSrc1, idAluSrc2  input  2 each  ALU operand selects
idAluOperation  input  3  ALU operation class
idPc, idRs1Data, idRs2Data, idImmediate  input  DATA_WIDTH each  decode-stage values
idRs1, idRs2, idRd  input  REG_ADDR_WIDTH each  register indices
idUsesRs1, idUsesRs2  input  1 each  instruction actually reads rs1/rs2
idFunct3  input  3  funct3 field
idFunct7b5  input  1  funct7 bit 5
flush  input  1  EX resolved taken branch/jump; kill the decode slot
hold  input  1  downstream (MEM) stall; freeze this register
exValid  output  1  EX slot holds a real instruction
ex*  output  same as id*  registered copies of every id* data/control input above except idUsesRs1/2
stallOut  output  1  combinational; freeze PC and IF/ID this cycle
bubbleCount  output  CNT_WIDTH  saturating count of load-use bubbles

Behaviour:
- Reset: when rstN=0, all ex* outputs, exValid and bubbleCount go to 0 immediately (asynchronous). Reset released synchronously to clk by the top level.
- Latency: one cycle, ID to EX. Outputs are registered except stallOut.
- Load-use hazard (combinational), asserted when all of the following hold:
  - exValid & exMemoryReadEnable & (exRd != 0) & idValid
  - and either (idUsesRs1 & idRs1 == exRd) or (idUsesRs2 & idRs2 == exRd)
- Per-cycle priority, highest first:
  1. flush: exValid<=0; exMemoryReadEnable, exMemoryWriteEnable, exRegisterWriteEnable and exPcUpdate <=0; stallOut=0, even if hold or hazard is also true.
  2. hold: all ex* registers retain their values; stallOut=1; counter unchanged.
  3. hazard: insert a bubble: exValid<=0, the four enables <=0, other ex* don't-care but driven 0; stallOut=1; bubbleCount increments.
  4. normal: every ex* <= id*; exValid<=idValid.
- Bubble sanitisation: whenever idValid=0 in the normal case, the four enables are forced to 0 in EX. X values from the control unit's default branch must never reach EX when invalid.
- Register x0: rd=0 never triggers a hazard. A load to x0 followed by a use of x0 gives no stall.
- The hazard lasts exactly one cycle per load: the bubble clears exValid, so the next cycle proceeds with no double stall.
- bubbleCount saturates at 2^CNT_WIDTH-1 and does not wrap.
- Reset in mid-stall: after reset, exValid=0, so stallOut=0 unless hold=1.

Test Plan:
- Reset: rstN low mid-run with exValid=1 -> all ex* and bubbleCount read 0 before the next clk edge; stallOut=0.
- Pass-through: an ADD (idValid=1, RegisterWriteEnable=1, AluOperation=3'b010, Rs1Data=5, Rs2Data=7, Rd=3) -> next cycle exValid=1, exAluOperation=3'b010, exRs1Data=5, exRd=3.
- Load-use: LW with Rd=4 in EX, then ADD with Rs2=4 and idUsesRs2=1 in ID -> stallOut=1 for one cycle, exValid=0 next cycle, bubbleCount 0->1; the ADD enters EX on the following cycle.
- Flush over hazard: the same load-use setup plus flush=1 -> stallOut=0, exValid=0, bubbleCount unchanged; also check flush with hold=1 gives exValid=0.
- Hold: hold=1 for 3 cycles with exRd=9 -> ex* stable at exRd=9 and stallOut=1 throughout; a load to x0 followed by a use of x0 gives stallOut=0.
- Saturation: CNT_WIDTH=2 and 5 consecutive load-use pairs -> bubbleCount reads 1, 2, 3, 3, 3.
